jt03_bus_master: RTL
====================

JT03_BUS_MASTER -- requirements
Module: jt03_bus_master

Interface
REQ-001 Parameter WR_W, default 2: cen cycles for which bus_cs_n/bus_wr_n are held low per write; legal range >=1.
REQ-002 Parameter GAP, default 4: idle cen cycles after the address write; legal range >=0, with 0 skipping the GAP state.
REQ-003 Parameter TMO, default 255: consecutive busy samples before timeout; legal range 1..255.
REQ-004 clk  in  1  system clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  reset; one clock domain, asynchronous assertion, active-low.
REQ-006 cen  in  1  clock enable; the FSM and counters advance only on edges with cen=1.
REQ-007 req_valid  in  1  register-write request present.
REQ-008 req_ready  out  1  block can accept a request; high only in IDLE.
REQ-009 req_reg  in  8  chip register index.
REQ-010 req_data  in  8  value to write.
REQ-011 bus_din  out  8  data to chip din.
REQ-012 bus_addr  out  1  chip address line: 0 = register select, 1 = data.
REQ-013 bus_cs_n  out  1  chip select, active-low.
REQ-014 bus_wr_n  out  1  write strobe, active-low.
REQ-015 bus_dout  in  8  chip status; bit 7 = busy.
REQ-016 busy  out  1  high whenever the state is not IDLE.
REQ-017 err_tmo  out  1  sticky busy-timeout flag.
REQ-018 err_clr  in  1  clears err_tmo.

Function
REQ-019 The FSM SHALL have exactly these states: IDLE, POLL_A, WR_A, GAP, POLL_D, WR_D.
REQ-020 A request SHALL be accepted on an edge with req_valid=1, req_ready=1 and cen=1; req_reg and req_data are latched at that edge, then IDLE->POLL_A.
REQ-021 On entering POLL_A, bus_addr SHALL be set to 0 and bus_din to the latched reg; on entering POLL_D, bus_addr SHALL be set to 1 and bus_din to the latched data; both hold until the next such entry (setup before the strobe, hold after it).
REQ-022 POLL_x: bus_cs_n=1 and bus_wr_n=1; bus_dout[7] sampled once per cen edge; 0 -> next state (WR_A or WR_D) with poll counter cleared.
REQ-023 POLL_x with bus_dout[7]=1: poll counter increments; on the TMO-th consecutive busy sample, err_tmo is set and the FSM proceeds to the write state anyway.
REQ-024 WR_x: bus_cs_n=0 and bus_wr_n=0 for exactly WR_W cen cycles; WR_A then goes to GAP (or POLL_D when GAP=0); WR_D then goes to IDLE.
REQ-025 GAP: strobes high for exactly GAP cen cycles, then POLL_D.
REQ-026 All bus outputs SHALL be registered, with no combinational path from inputs.
REQ-027 With bus_dout[7]=0 throughout, the non-IDLE time SHALL be exactly 2*WR_W+GAP+2 cen cycles (10 with defaults).
REQ-028 A new request SHALL be acceptable on the first cen edge after return to IDLE; back-to-back requests SHALL need no extra idle cycle.
REQ-029 cen=0 SHALL freeze state, counters and all outputs, including mid-strobe.
REQ-030 err_clr=1 SHALL clear err_tmo on the next clk edge (not cen-qualified); if a set event coincides, the set wins.
REQ-031 req_valid dropped before acceptance SHALL have no effect; requests arriving while busy are not accepted.

Reset
REQ-032 While rst_n=0: state IDLE, bus_cs_n=1, bus_wr_n=1, bus_addr=0, bus_din=0x00, err_tmo=0, counters 0, busy=0, req_ready=1.
REQ-033 Reset asserted mid-write SHALL raise the strobes immediately (asynchronously), and the pending request is discarded.

Verification
REQ-034 Idle chip, cen=1, request reg=0x28 data=0xF1 -> bus_addr=0/bus_din=0x28 with wr_n low 2 cycles, 4-cycle gap, bus_addr=1/bus_din=0xF1 with wr_n low 2 cycles; busy for 10 cycles.
REQ-035 bus_dout[7]=1 for 5 samples before the data write -> POLL_D lasts 6 cen cycles; err_tmo stays 0.
REQ-036 TMO=3, bus_dout[7] stuck at 1 -> err_tmo=1 after the 3rd busy sample, write still issued, and err_clr returns it to 0.
REQ-037 cen toggling 1,0,1,0 during WR_A -> wr_n low for 2 enabled cycles (4 clk), with outputs stable while cen=0.
REQ-038 rst_n low in the 1st WR_D cycle -> cs_n=wr_n=1 without waiting for clk, busy=0 and req_ready=1 after release.
REQ-039 Two requests with req_valid held high -> second accepted on the first IDLE cen edge, giving 20 busy cycles total.

Source files
------------

// File: rtl/jt03_bus_master.sv
// jt03_bus_master: serialises register writes onto a YM-style chip bus (address write, gap, data write)
//   clk, rst_n          clock, asynchronous active-low reset
//   cen                 clock enable; FSM, counters and outputs advance only when high
//   req_valid/req_ready request handshake; req_reg/req_data latched on acceptance
//   bus_din, bus_addr   registered chip data bus and address line (0 = register, 1 = data)
//   bus_cs_n, bus_wr_n  registered active-low chip select and write strobe
//   bus_dout            chip status, bit 7 = busy
//   busy                high whenever a write sequence is in progress
//   err_tmo, err_clr    sticky busy-timeout flag and its clear
module jt03_bus_master #(
  parameter int WR_W = 2,
  parameter int GAP  = 4,
  parameter int TMO  = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_data,
  output logic [7:0] bus_din,
  output logic       bus_addr,
  output logic       bus_cs_n,
  output logic       bus_wr_n,
  input  logic [7:0] bus_dout,
  output logic       busy,
  output logic       err_tmo,
  input  logic       err_clr
);
  typedef enum logic [2:0] {S_IDLE, S_POLL_A, S_WR_A, S_GAP, S_POLL_D, S_WR_D} state_t;
  localparam logic [15:0] WR_LAST  = 16'(WR_W - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP > 0 ? GAP - 1 : 0);
  localparam logic [7:0]  TMO_LAST = 8'(TMO - 1);
  state_t      state, nxt;
  logic [15:0] cnt;
  logic [7:0]  pcnt, data_q, nxt_din;
  logic        polling, chip_busy, tmo_hit, cnt_done, enter_a, enter_d;
  logic        nxt_strobe, nxt_addr;
  logic        unused;
  assign unused    = ^bus_dout[6:0];
  assign polling   = state == S_POLL_A || state == S_POLL_D;
  assign chip_busy = bus_dout[7];
  // the TMO-th consecutive busy sample gives up waiting and writes anyway
  assign tmo_hit   = polling && chip_busy && pcnt == TMO_LAST;
  assign cnt_done  = cnt == (state == S_GAP ? GAP_LAST : WR_LAST);
  assign busy      = state != S_IDLE;
  assign req_ready = state == S_IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else if (cen) state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (req_valid) nxt = S_POLL_A;
      S_POLL_A: if (!chip_busy || tmo_hit) nxt = S_WR_A;
      S_WR_A:   if (cnt_done) nxt = GAP > 0 ? S_GAP : S_POLL_D;
      S_GAP:    if (cnt_done) nxt = S_POLL_D;
      S_POLL_D: if (!chip_busy || tmo_hit) nxt = S_WR_D;
      S_WR_D:   if (cnt_done) nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end
  // outputs are computed from the next state and registered, so the bus never sees an input combinationally
  always_comb begin
    enter_a    = state == S_IDLE && nxt == S_POLL_A;
    enter_d    = state != S_POLL_D && nxt == S_POLL_D;
    nxt_strobe = nxt == S_WR_A || nxt == S_WR_D;
    nxt_addr   = enter_a ? 1'b0 : enter_d ? 1'b1 : bus_addr;
    nxt_din    = enter_a ? req_reg : enter_d ? data_q : bus_din;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt      <= '0;
      pcnt     <= '0;
      data_q   <= '0;
      bus_cs_n <= 1'b1;
      bus_wr_n <= 1'b1;
      bus_addr <= 1'b0;
      bus_din  <= '0;
    end else if (cen) begin
      cnt      <= nxt != state || polling || state == S_IDLE ? 16'd0 : cnt + 16'd1;
      pcnt     <= polling && chip_busy && !tmo_hit ? pcnt + 8'd1 : 8'd0;
      data_q   <= enter_a ? req_data : data_q;
      bus_cs_n <= !nxt_strobe;
      bus_wr_n <= !nxt_strobe;
      bus_addr <= nxt_addr;
      bus_din  <= nxt_din;
    end
  // clear is not cen-qualified; a coinciding timeout takes priority
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_tmo <= 1'b0;
    else if (cen && tmo_hit) err_tmo <= 1'b1;
    else if (err_clr) err_tmo <= 1'b0;
endmodule
